picorv32_mem_prefetch_buffer: RTL and testbench
===============================================

Name: picorv32_mem_prefetch_buffer

Overview:
- Single-line instruction prefetch buffer on the PicoRV32 native memory interface.
- Sits between the PicoRV32 core (upstream, `cpu_*` ports) and the PicoRV32-to-FreeAHB adapter (downstream, `mem_*` ports).
- Both sides use the same native valid/ready protocol.
- Cacheable instruction fetches are served from a LINE_WORDS-word line, filled critical-word-first with wrap-around.
- Data reads, writes and non-cacheable fetches pass through unchanged.

Parameters:
- LINE_WORDS, 4, words per line; power of two, 2..16.
- CACHEABLE_BASE, 32'h0000_0000, base of the cacheable region.
- CACHEABLE_MASK, 32'hF000_0000, region mask; an address is cacheable iff (addr & MASK) == BASE.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  invalidate line (single-cycle pulse)
- cpu_mem_valid  in  1  core request
- cpu_mem_instr  in  1  instruction fetch
- cpu_mem_ready  out  1  registered one-cycle completion pulse
- cpu_mem_addr  in  32  byte address
- cpu_mem_wdata  in  32  write data
- cpu_mem_wstrb  in  4  byte strobes; 0 = read
- cpu_mem_rdata  out  32  registered read data
- mem_valid  out  1  downstream request
- mem_instr  out  1  downstream instruction flag
- mem_ready  in  1  downstream completion
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_wstrb  out  4  downstream strobes
- mem_rdata  in  32  downstream read data

Behaviour:
- Reset (async, resetn=0):
  - All outputs driven 0.
  - Tag and data registers cleared; valid bits all cleared.
  - State = IDLE.
  - Reset mid-operation drops mem_valid immediately; no transaction resumes.
- Storage:
  - tag = addr[31:2+log2(LINE_WORDS)].
  - Data array of LINE_WORDS x 32, plus one valid bit per word.
- Classification, sampled in IDLE while cpu_mem_valid=1 and cpu_mem_ready=0:
  - HIT: instr=1, wstrb=0, cacheable, tag match, word valid bit set.
  - FILL: instr=1, wstrb=0, cacheable, not a hit.
  - PASS: everything else.
- States: IDLE, HIT_RSP, PASS, FILL, FILL_GAP, WAIT_DROP.
- IDLE -> HIT_RSP:
  - Next cycle cpu_mem_ready=1 and cpu_mem_rdata = line word.
  - Hit latency is exactly 1 cycle; no downstream activity.
- IDLE -> PASS:
  - Registers addr/wdata/wstrb/instr onto mem_*, mem_valid=1.
  - On mem_ready=1: mem_valid=0; next cycle cpu_mem_ready=1 with cpu_mem_rdata = mem_rdata captured on the mem_ready cycle.
  - Write with tag match: all valid bits cleared on the mem_ready cycle.
- IDLE -> FILL:
  - Tag loaded, all valid bits cleared.
  - First downstream word = requested word; mem_addr word index increments mod LINE_WORDS (wrap inside the aligned line).
  - mem_instr=1, mem_wstrb=0.
  - Each mem_ready: store word, set its valid bit, mem_valid=0, enter FILL_GAP for exactly one cycle (mem_valid low at least one cycle between transfers), then issue the next word.
  - First word returned: cpu_mem_ready pulses on the next cycle with that word (early restart).
  - After LINE_WORDS words -> IDLE.
- New core requests arriving during FILL/FILL_GAP stall (no ready) until the fill ends, then are classified normally.
- WAIT_DROP:
  - Entered after every cpu_mem_ready pulse.
  - Waits one cycle so the core can deassert or change its request before re-classification.
- flush:
  - In IDLE: clears valid bits next cycle.
  - During FILL: current downstream transfer completes, no further words are issued, valid bits are cleared, then -> IDLE.
  - If the critical word was still outstanding, the core still receives it.
  - flush together with a same-cycle hit: flush wins; the request is treated as a miss.
- mem_ready while mem_valid=0 is ignored.
- cpu_mem_ready is never asserted for more than one cycle per request.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- Defined:
  - Adds outputs stat_hits[31:0] and stat_misses[31:0], reset to 0.
  - stat_hits +1 per HIT classification; stat_misses +1 per FILL classification.
  - Both counters saturate at 32'hFFFF_FFFF; flush does not clear them.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Miss wrap, LINE_WORDS=4: instr read 0x0000_0108 -> downstream reads 0x108, 0x10C, 0x100, 0x104, each separated by >=1 idle cycle; cpu_mem_ready 1 cycle after the first mem_ready, rdata = mem word at 0x108.
- Hit after fill: instr read 0x0000_0100 -> cpu_mem_ready 1 cycle after sampling, mem_valid stays 0, correct data.
- Write invalidate: write 0x104 with wstrb=4'b0011, wdata 0xDEADBEEF -> identical downstream write; then instr read 0x100 -> full refill starting at 0x100.
- Pass-through: data read (instr=0) at 0x10C, and instr read at 0x8000_0000 -> one downstream read each; the line is untouched and a later 0x10C fetch still hits.
- Stall during fill: core issues instr read 0x200 right after the early-restart pulse -> no ready until the 0x100 line completes, then a fill of the 0x200 line.
- Disruption: flush during the second fill word -> exactly 2 downstream words, line invalid afterwards; resetn=0 mid-fill -> mem_valid=0 at once, stats (if enabled) read 0.

Source files
------------

// File: rtl/picorv32_mem_prefetch_buffer.sv
// picorv32_mem_prefetch_buffer
// Single-line instruction prefetch buffer between the PicoRV32 native memory
// port (cpu_*) and the downstream adapter (mem_*). Cacheable instruction
// fetches are served from one LINE_WORDS-word line that is filled
// critical-word-first with wrap-around inside the aligned line; data reads,
// writes and non-cacheable fetches pass straight through.
// Optional: define PREFETCH_STATS_EN to add saturating hit/miss counters
// (stat_hits / stat_misses).
module picorv32_mem_prefetch_buffer #(
    parameter int          LINE_WORDS     = 4,
    parameter logic [31:0] CACHEABLE_BASE = 32'h0000_0000,
    parameter logic [31:0] CACHEABLE_MASK = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        cpu_mem_valid,
    input  logic        cpu_mem_instr,
    output logic        cpu_mem_ready,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic [31:0] cpu_mem_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIT_RSP,
        ST_PASS,
        ST_FILL,
        ST_FILL_GAP,
        ST_WAIT_DROP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [TAG_W-1:0]      tag_q;
    logic [31:0]           line_q [LINE_WORDS];
    logic [LINE_WORDS-1:0] vbits_q;
    logic [IDX_W-1:0]      fill_cnt_q;    // words received so far in this fill
    logic                  crit_pend_q;   // requested word not yet handed to the core
    logic                  flush_pend_q;  // flush seen while a fill word was in flight

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] mem_tag;
    logic [IDX_W-1:0] mem_idx;

    logic fetch_req;
    logic line_hit;
    logic sample;
    logic cls_hit;
    logic cls_fill;
    logic cls_pass;
    logic xfer;
    logic fill_stop;
    logic fill_last;

    assign req_tag = cpu_mem_addr[31:2+IDX_W];
    assign req_idx = cpu_mem_addr[IDX_W+1:2];
    assign mem_tag = mem_addr[31:2+IDX_W];
    assign mem_idx = mem_addr[IDX_W+1:2];

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cls_hit)       state_nxt = ST_HIT_RSP;
                else if (cls_fill) state_nxt = ST_FILL;
                else if (cls_pass) state_nxt = ST_PASS;
            end
            ST_HIT_RSP:   state_nxt = ST_WAIT_DROP;
            ST_PASS:      if (xfer) state_nxt = ST_WAIT_DROP;
            ST_FILL: begin
                // A fill cut short before the critical word arrived still
                // owes the core its ready pulse, so it needs the drop cycle.
                if (xfer) begin
                    if (!fill_last)       state_nxt = ST_FILL_GAP;
                    else if (crit_pend_q) state_nxt = ST_WAIT_DROP;
                    else                  state_nxt = ST_IDLE;
                end
            end
            ST_FILL_GAP:  state_nxt = fill_stop ? ST_IDLE : ST_FILL;
            // Hold while the ready pulse is out, then one more cycle so the
            // core can retract or replace its request.
            ST_WAIT_DROP: if (!cpu_mem_ready) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Request classification and transfer strobes steering the datapath
    always_comb begin
        fetch_req = cpu_mem_instr && (cpu_mem_wstrb == 4'b0000) &&
                    ((cpu_mem_addr & CACHEABLE_MASK) == CACHEABLE_BASE);
        // A same-cycle flush turns a would-be hit into a miss.
        line_hit  = fetch_req && (tag_q == req_tag) && vbits_q[req_idx] && !flush;
        sample    = (state == ST_IDLE) && cpu_mem_valid && !cpu_mem_ready;
        cls_hit   = sample && line_hit;
        cls_fill  = sample && fetch_req && !line_hit;
        cls_pass  = sample && !fetch_req;
        xfer      = mem_valid && mem_ready;
        fill_stop = flush || flush_pend_q;
        fill_last = (fill_cnt_q == IDX_W'(LINE_WORDS - 1)) || fill_stop;
    end

    // Line storage, downstream request registers and core response registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cpu_mem_ready <= 1'b0;
            cpu_mem_rdata <= '0;
            mem_valid     <= 1'b0;
            mem_instr     <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            tag_q         <= '0;
            vbits_q       <= '0;
            fill_cnt_q    <= '0;
            crit_pend_q   <= 1'b0;
            flush_pend_q  <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) line_q[i] <= '0;
        end else begin
            cpu_mem_ready <= 1'b0;

            if (flush && state != ST_FILL && state != ST_FILL_GAP)
                vbits_q <= '0;

            if (cls_hit) begin
                cpu_mem_ready <= 1'b1;
                cpu_mem_rdata <= line_q[req_idx];
            end

            if (cls_pass) begin
                mem_valid <= 1'b1;
                mem_instr <= cpu_mem_instr;
                mem_addr  <= cpu_mem_addr;
                mem_wdata <= cpu_mem_wdata;
                mem_wstrb <= cpu_mem_wstrb;
            end

            if (cls_fill) begin
                tag_q        <= req_tag;
                vbits_q      <= '0;
                mem_valid    <= 1'b1;
                mem_instr    <= 1'b1;
                mem_wstrb    <= 4'b0000;
                mem_addr     <= {cpu_mem_addr[31:2], 2'b00};
                fill_cnt_q   <= '0;
                crit_pend_q  <= 1'b1;
                flush_pend_q <= 1'b0;
            end

            if (state == ST_PASS && xfer) begin
                mem_valid     <= 1'b0;
                cpu_mem_ready <= 1'b1;
                cpu_mem_rdata <= mem_rdata;
                if ((mem_wstrb != 4'b0000) && (mem_tag == tag_q))
                    vbits_q <= '0;
            end

            if (state == ST_FILL) begin
                if (flush) flush_pend_q <= 1'b1;
                if (xfer) begin
                    mem_valid       <= 1'b0;
                    line_q[mem_idx] <= mem_rdata;
                    fill_cnt_q      <= fill_cnt_q + 1'b1;
                    if (fill_stop) begin
                        vbits_q      <= '0;
                        flush_pend_q <= 1'b0;
                    end else begin
                        vbits_q[mem_idx] <= 1'b1;
                    end
                    // Early restart: the requested word goes to the core as
                    // soon as it lands.
                    if (crit_pend_q) begin
                        cpu_mem_ready <= 1'b1;
                        cpu_mem_rdata <= mem_rdata;
                        crit_pend_q   <= 1'b0;
                    end
                end
            end

            if (state == ST_FILL_GAP) begin
                if (fill_stop) begin
                    vbits_q      <= '0;
                    flush_pend_q <= 1'b0;
                end else begin
                    mem_valid             <= 1'b1;
                    mem_addr[IDX_W+1:2]   <= mem_idx + 1'b1;
                end
            end
        end
    end

`ifdef PREFETCH_STATS_EN
    // Saturating hit/miss counters; only reset clears them
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (cls_hit && stat_hits != 32'hFFFF_FFFF)
                stat_hits <= stat_hits + 1'b1;
            if (cls_fill && stat_misses != 32'hFFFF_FFFF)
                stat_misses <= stat_misses + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_picorv32_mem_prefetch_buffer.sv
// tb_picorv32_mem_prefetch_buffer
// Scoreboard bench: each core request pushes its expected downstream
// transactions and its expected response word; a monitor pops and compares
// them as the DUT produces them. A latency-randomised memory model answers
// downstream requests and also drives stray mem_ready while mem_valid is low.
module tb_picorv32_mem_prefetch_buffer;

    localparam int LW     = 4;
    localparam int K_HIT  = 0;
    localparam int K_FILL = 1;
    localparam int K_PASS = 2;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        cpu_mem_valid;
    logic        cpu_mem_instr;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic [31:0] cpu_mem_rdata;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
`ifdef PREFETCH_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    picorv32_mem_prefetch_buffer #(
        .LINE_WORDS     (LW),
        .CACHEABLE_BASE (32'h0000_0000),
        .CACHEABLE_MASK (32'hF000_0000)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .flush         (flush),
        .cpu_mem_valid (cpu_mem_valid),
        .cpu_mem_instr (cpu_mem_instr),
        .cpu_mem_ready (cpu_mem_ready),
        .cpu_mem_addr  (cpu_mem_addr),
        .cpu_mem_wdata (cpu_mem_wdata),
        .cpu_mem_wstrb (cpu_mem_wstrb),
        .cpu_mem_rdata (cpu_mem_rdata),
        .mem_valid     (mem_valid),
        .mem_instr     (mem_instr),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rdata     (mem_rdata)
`ifdef PREFETCH_STATS_EN
        ,
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        instr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } down_t;

    typedef struct {
        logic [31:0] rdata;
        int          kind;
    } rsp_t;

    down_t down_q[$];
    rsp_t  rsp_q[$];

    int n_chk;
    int n_err;
    int exp_hits;
    int exp_misses;

    logic prev_valid;
    logic prev_xfer;
    logic prev_rdy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0] ^ a[31:16], a[15:0]};
    endfunction

    // Downstream memory model
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!mem_valid) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
                wait_cnt  = int'($urandom_range(0, 2));
            end else if (wait_cnt == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem_word(mem_addr);
                wait_cnt  = 3;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
                wait_cnt--;
            end
        end
    end

    // Monitor: downstream transactions and core responses against the scoreboard
    always @(negedge clk) begin
        down_t d;
        rsp_t  r;
        if (!resetn) begin
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
            prev_rdy   = 1'b0;
        end else begin
            if (mem_valid && !prev_valid) begin
                check("down_pending", 32'(down_q.size() != 0), 32'd1);
                if (down_q.size() != 0) begin
                    d = down_q.pop_front();
                    check("down_addr",  mem_addr,  d.addr);
                    check("down_instr", 32'(mem_instr), 32'(d.instr));
                    check("down_wstrb", 32'(mem_wstrb), 32'(d.wstrb));
                    if (d.wstrb != 4'b0000) check("down_wdata", mem_wdata, d.wdata);
                end
            end
            if (prev_xfer) check("down_gap", 32'(mem_valid), 32'd0);
            if (cpu_mem_ready) begin
                check("rdy_one_cycle", 32'(prev_rdy), 32'd0);
                check("rsp_pending", 32'(rsp_q.size() != 0), 32'd1);
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    check("rsp_rdata", cpu_mem_rdata, r.rdata);
                    if (r.kind != K_HIT) check("rsp_after_xfer", 32'(prev_xfer), 32'd1);
                end
            end
            prev_valid = mem_valid;
            prev_xfer  = mem_valid && mem_ready;
            prev_rdy   = cpu_mem_ready;
        end
    end

    task automatic cpu_req(input logic [31:0] addr, input logic instr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input int kind, input int nwords,
                           input logic with_flush, input logic gap);
        int          lat;
        int          idx;
        logic [31:0] base;
        down_t       d;
        rsp_t        r;
        r.rdata = mem_word(addr);
        r.kind  = kind;
        rsp_q.push_back(r);
        if (kind == K_PASS) begin
            d.addr = addr; d.instr = instr; d.wstrb = wstrb; d.wdata = wdata;
            down_q.push_back(d);
        end else if (kind == K_FILL) begin
            base = addr & ~32'(LW * 4 - 1);
            idx  = int'((addr >> 2) & 32'(LW - 1));
            for (int i = 0; i < nwords; i++) begin
                d.addr  = base | 32'(((idx + i) % LW) * 4);
                d.instr = 1'b1; d.wstrb = 4'b0000; d.wdata = 32'h0;
                down_q.push_back(d);
            end
            exp_misses++;
        end else begin
            exp_hits++;
        end
        cpu_mem_addr  = addr;
        cpu_mem_instr = instr;
        cpu_mem_wstrb = wstrb;
        cpu_mem_wdata = wdata;
        cpu_mem_valid = 1'b1;
        flush         = with_flush;
        lat = 0;
        do begin
            @(posedge clk); #1;
            flush = 1'b0;
            lat++;
        end while (!cpu_mem_ready && lat < 200);
        check("req_done", 32'(cpu_mem_ready), 32'd1);
        if (kind == K_HIT) check("hit_latency", 32'(lat), 32'd1);
        @(posedge clk); #1;
        cpu_mem_valid = 1'b0;
        cpu_mem_instr = 1'b0;
        cpu_mem_wstrb = 4'b0000;
        cpu_mem_wdata = 32'h0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((down_q.size() != 0 || mem_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("quiet", 32'(n < 300), 32'd1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_stats();
`ifdef PREFETCH_STATS_EN
        check("stat_hits",   stat_hits,   32'(exp_hits));
        check("stat_misses", stat_misses, 32'(exp_misses));
`endif
    endtask

    initial begin
        int n;
        n_chk = 0; n_err = 0; exp_hits = 0; exp_misses = 0;
        resetn = 1'b0; flush = 1'b0;
        cpu_mem_valid = 1'b0; cpu_mem_instr = 1'b0; cpu_mem_addr = 32'h0;
        cpu_mem_wdata = 32'h0; cpu_mem_wstrb = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_ready", 32'(cpu_mem_ready), 32'd0);
        check("rst_cpu_rdata", cpu_mem_rdata, 32'h0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_instr", 32'(mem_instr), 32'd0);
        check("rst_mem_addr",  mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check_stats();
        resetn = 1'b1;
        @(posedge clk); #1;

        // Miss with wrap: 0x108, 0x10C, 0x100, 0x104
        cpu_req(32'h0000_0108, 1'b1, 4'b0000, 32'h0, K_FILL, LW, 1'b0, 1'b1);
        wait_quiet();

        // Hits from the filled line
        cpu_req(32'h0000_0100, 1'b1, 4'b0000, 32'h0, K_HIT, 0, 1'b0, 1'b1);
        cpu_req(32'h0000_0104, 1'b1, 4'b0000, 32'h0, K_HIT, 0, 1'b0, 1'b1);
        cpu_req(32'h0000_010C, 1'b1, 4'b0000, 32'h0, K_HIT, 0, 1'b0, 1'b1);

        // Write into the line invalidates it; next fetch refills from 0x100
        cpu_req(32'h0000_0104, 1'b0, 4'b0011, 32'hDEAD_BEEF, K_PASS, 1, 1'b0, 1'b1);
        cpu_req(32'h0000_0100, 1'b1, 4'b0000, 32'h0, K_FILL, LW, 1'b0, 1'b1);
        wait_quiet();

        // Pass-through data read and non-cacheable fetch leave the line alone
        cpu_req(32'h0000_010C, 1'b0, 4'b0000, 32'h0, K_PASS, 1, 1'b0, 1'b1);
        cpu_req(32'h8000_0000, 1'b1, 4'b0000, 32'h0, K_PASS, 1, 1'b0, 1'b1);
        cpu_req(32'h0000_010C, 1'b1, 4'b0000, 32'h0, K_HIT, 0, 1'b0, 1'b1);

        // Flush while idle, then a fetch that stalls behind the refill
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
        cpu_req(32'h0000_0100, 1'b1, 4'b0000, 32'h0, K_FILL, LW, 1'b0, 1'b0);
        cpu_req(32'h0000_0200, 1'b1, 4'b0000, 32'h0, K_FILL, LW, 1'b0, 1'b1);
        wait_quiet();
        cpu_req(32'h0000_0208, 1'b1, 4'b0000, 32'h0, K_HIT, 0, 1'b0, 1'b1);

        // Flush in the same cycle as a would-be hit forces a miss
        cpu_req(32'h0000_0204, 1'b1, 4'b0000, 32'h0, K_FILL, LW, 1'b1, 1'b1);
        wait_quiet();

        // Flush during the second fill word: exactly two downstream words
        cpu_req(32'h0000_0300, 1'b1, 4'b0000, 32'h0, K_FILL, 2, 1'b0, 1'b0);
        n = 0;
        while (!mem_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("second_word_issued", 32'(mem_valid), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_quiet();
        cpu_req(32'h0000_0304, 1'b1, 4'b0000, 32'h0, K_FILL, LW, 1'b0, 1'b1);
        wait_quiet();
        check_stats();

        // Reset in the middle of a fill
        cpu_mem_addr  = 32'h0000_0400;
        cpu_mem_instr = 1'b1;
        cpu_mem_wstrb = 4'b0000;
        cpu_mem_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!mem_valid && n < 20);
        check("fill_started", 32'(mem_valid), 32'd1);
        resetn = 1'b0;
        #1;
        check("midrst_mem_valid", 32'(mem_valid), 32'd0);
        check("midrst_cpu_ready", 32'(cpu_mem_ready), 32'd0);
        check("midrst_mem_addr",  mem_addr, 32'h0);
        cpu_mem_valid = 1'b0;
        cpu_mem_instr = 1'b0;
        cpu_mem_addr  = 32'h0;
        down_q.delete();
        rsp_q.delete();
        exp_hits   = 0;
        exp_misses = 0;
        check_stats();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(mem_valid), 32'd0);

        // Line is invalid after reset: a fetch must refill
        cpu_req(32'h0000_0100, 1'b1, 4'b0000, 32'h0, K_FILL, LW, 1'b0, 1'b1);
        wait_quiet();
        check_stats();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
